// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: gathers keypad digits into an N-digit store and drives
// per-digit segment codes in plain, masked or positional-fill display modes.
module keypad_entry_buffer #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned KEY_W      = 5,
    parameter logic [3:0]  MASK_CODE  = 4'd10,
    parameter logic [3:0]  PLACE_CODE = 4'd13,
    parameter logic [3:0]  BLANK_CODE = 4'd15,
    localparam int unsigned CNT_W     = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_ready,
    input  logic [KEY_W-1:0]        keycode,
    input  logic [1:0]              mode,
    output logic [4*NUM_DIGITS-1:0] seg_data,
    output logic [4*NUM_DIGITS-1:0] entry_value,
    output logic [CNT_W-1:0]        digit_count,
    output logic                    full,
    output logic                    entry_done,
    output logic                    key_reject
);

    localparam logic [1:0] StEmpty  = 2'd0;
    localparam logic [1:0] StEntry  = 2'd1;
    localparam logic [1:0] StFull   = 2'd2;
    localparam logic [1:0] StLocked = 2'd3;

    localparam logic [1:0] ModePlain = 2'd0;
    localparam logic [1:0] ModeMask  = 2'd1;
    localparam logic [1:0] ModePos   = 2'd2;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(NUM_DIGITS);

    logic                         key_ready_q;
    logic [1:0]                   state_q, state_d;
    logic [1:0]                   amode_q, amode_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [NUM_DIGITS-1:0][3:0]   store_q, store_d;
    logic [NUM_DIGITS-1:0][3:0]   seg_q, seg_d;
    logic                         done_q, done_d;
    logic                         reject_q, reject_d;

    logic        key_event;
    logic [31:0] key_val;
    logic [3:0]  digit;
    logic [1:0]  norm_mode;
    logic [1:0]  use_mode;
    logic [CNT_W-1:0] cnt_dec;
    logic        is_digit, is_clear, is_bksp, is_enter;
    logic        can_edit;

    assign key_event = key_ready_q & ~key_ready;
    assign key_val   = 32'(keycode);
    assign digit     = key_val[3:0];
    assign is_digit  = (key_val < 32'd10);
    assign is_clear  = (key_val == 32'd16);
    assign is_bksp   = (key_val == 32'd17);
    assign is_enter  = (key_val == 32'd18);
    assign norm_mode = (mode == 2'b11) ? ModePlain : mode;
    assign cnt_dec   = count_q - CNT_W'(1);
    assign can_edit  = (state_q == StEntry) || (state_q == StFull);
    // The display mode is only taken from the input on the first digit of an entry.
    assign use_mode  = (state_q == StEmpty) ? norm_mode : amode_q;

    always_comb begin
        state_d  = state_q;
        amode_d  = amode_q;
        count_d  = count_q;
        store_d  = store_q;
        done_d   = 1'b0;
        reject_d = 1'b0;

        if (key_event) begin
            if (is_clear) begin
                state_d = StEmpty;
                amode_d = ModePlain;
                count_d = '0;
                store_d = '0;
            end else if (is_digit) begin
                if ((state_q == StEmpty) || (state_q == StEntry)) begin
                    amode_d = use_mode;
                    if (use_mode == ModePos) begin
                        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                            if (CNT_W'(i) == count_q) store_d[i] = digit;
                        end
                    end else begin
                        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
                            store_d[i] = store_q[i-1];
                        end
                        store_d[0] = digit;
                    end
                    count_d = count_q + CNT_W'(1);
                    state_d = (count_d == CntMax) ? StFull : StEntry;
                end else begin
                    reject_d = 1'b1;
                end
            end else if (is_bksp) begin
                if (can_edit) begin
                    if (amode_q == ModePos) begin
                        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                            if (CNT_W'(i) == cnt_dec) store_d[i] = 4'd0;
                        end
                    end else begin
                        for (int unsigned i = 0; i + 1 < NUM_DIGITS; i++) begin
                            store_d[i] = store_q[i+1];
                        end
                        store_d[NUM_DIGITS-1] = 4'd0;
                    end
                    count_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_d = StEmpty;
                        amode_d = ModePlain;
                    end else begin
                        state_d = StEntry;
                    end
                end else begin
                    reject_d = 1'b1;
                end
            end else if (is_enter) begin
                if (can_edit) begin
                    done_d  = 1'b1;
                    state_d = StLocked;
                end else begin
                    reject_d = 1'b1;
                end
            end
        end
    end

    // Display is built from the registered store, so it trails the store by one cycle.
    always_comb begin
        seg_d = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (CNT_W'(i) < count_q) begin
                seg_d[i] = (amode_q == ModeMask) ? MASK_CODE : store_q[i];
            end else begin
                seg_d[i] = (amode_q == ModePos) ? PLACE_CODE : BLANK_CODE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_ready_q <= 1'b0;
            state_q     <= StEmpty;
            amode_q     <= ModePlain;
            count_q     <= '0;
            store_q     <= '0;
            seg_q       <= {NUM_DIGITS{BLANK_CODE}};
            done_q      <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            key_ready_q <= key_ready;
            state_q     <= state_d;
            amode_q     <= amode_d;
            count_q     <= count_d;
            store_q     <= store_d;
            seg_q       <= seg_d;
            done_q      <= done_d;
            reject_q    <= reject_d;
        end
    end

    assign seg_data    = seg_q;
    assign entry_value = store_q;
    assign digit_count = count_q;
    assign full        = (count_q == CntMax);
    assign entry_done  = done_q;
    assign key_reject  = reject_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Self-checking bench for keypad_entry_buffer: directed vector table, corner-case
// sequences and a randomized run against an ordered-digit-list reference model.
module tb_keypad_entry_buffer;

    localparam int N = 4;
    localparam int KW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            key_ready = 1'b0;
    logic [KW-1:0]   keycode = '0;
    logic [1:0]      mode = 2'b00;
    logic [4*N-1:0]  seg_data;
    logic [4*N-1:0]  entry_value;
    logic [2:0]      digit_count;
    logic            full;
    logic            entry_done;
    logic            key_reject;

    int checks = 0;
    int failures = 0;

    keypad_entry_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .key_ready   (key_ready),
        .keycode     (keycode),
        .mode        (mode),
        .seg_data    (seg_data),
        .entry_value (entry_value),
        .digit_count (digit_count),
        .full        (full),
        .entry_done  (entry_done),
        .key_reject  (key_reject)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          code;
        int          md;
        logic [15:0] ev;
        logic [15:0] seg;
        int          cnt;
        bit          done;
        bit          rej;
    } vec_t;

    vec_t vecs[21];

    // Reference model: digits kept in entry order; positions derived on demand.
    int  m_q[$];
    int  m_mode;
    bit  m_locked;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        key_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        m_q.delete();
        m_mode = 0;
        m_locked = 0;
    endtask

    // Rising then falling strobe; returns pulses seen the cycle after the event.
    task automatic press(input int code, input int md, output logic done_s, output logic rej_s);
        keycode = KW'(code);
        mode = 2'(md);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        tick();
        done_s = entry_done;
        rej_s = key_reject;
        tick();
    endtask

    task automatic model_apply(input int code, input int md, output bit done, output bit rej);
        done = 0;
        rej = 0;
        if (code == 16) begin
            m_q.delete();
            m_locked = 0;
            m_mode = 0;
        end else if (code < 10) begin
            if (m_locked || m_q.size() == N) rej = 1;
            else begin
                if (m_q.size() == 0) m_mode = (md == 3) ? 0 : md;
                m_q.push_back(code);
            end
        end else if (code == 17) begin
            if (m_locked || m_q.size() == 0) rej = 1;
            else begin
                void'(m_q.pop_back());
                if (m_q.size() == 0) m_mode = 0;
            end
        end else if (code == 18) begin
            if (m_locked || m_q.size() == 0) rej = 1;
            else begin
                done = 1;
                m_locked = 1;
            end
        end
    endtask

    function automatic logic [15:0] model_entry();
        logic [15:0] v = '0;
        int sz = m_q.size();
        for (int i = 0; i < N; i++) begin
            if (i < sz) v[i*4 +: 4] = 4'((m_mode == 2) ? m_q[i] : m_q[sz-1-i]);
        end
        return v;
    endfunction

    function automatic logic [15:0] model_seg();
        logic [15:0] v;
        logic [15:0] e = model_entry();
        for (int i = 0; i < N; i++) begin
            if (i < m_q.size()) v[i*4 +: 4] = (m_mode == 1) ? 4'hA : e[i*4 +: 4];
            else v[i*4 +: 4] = (m_mode == 2) ? 4'hD : 4'hF;
        end
        return v;
    endfunction

    initial begin
        logic d_s, r_s;
        bit   md_done, md_rej;

        vecs[0]  = '{1,  0, 16'h0001, 16'hFFF1, 1, 0, 0};
        vecs[1]  = '{2,  0, 16'h0012, 16'hFF12, 2, 0, 0};
        vecs[2]  = '{3,  0, 16'h0123, 16'hF123, 3, 0, 0};
        vecs[3]  = '{4,  0, 16'h1234, 16'h1234, 4, 0, 0};
        vecs[4]  = '{5,  0, 16'h1234, 16'h1234, 4, 0, 1};
        vecs[5]  = '{16, 0, 16'h0000, 16'hFFFF, 0, 0, 0};
        vecs[6]  = '{7,  1, 16'h0007, 16'hFFFA, 1, 0, 0};
        vecs[7]  = '{8,  1, 16'h0078, 16'hFFAA, 2, 0, 0};
        vecs[8]  = '{17, 1, 16'h0007, 16'hFFFA, 1, 0, 0};
        vecs[9]  = '{16, 1, 16'h0000, 16'hFFFF, 0, 0, 0};
        vecs[10] = '{3,  2, 16'h0003, 16'hDDD3, 1, 0, 0};
        vecs[11] = '{9,  2, 16'h0093, 16'hDD93, 2, 0, 0};
        vecs[12] = '{5,  0, 16'h0593, 16'hD593, 3, 0, 0};
        vecs[13] = '{16, 0, 16'h0000, 16'hFFFF, 0, 0, 0};
        vecs[14] = '{18, 0, 16'h0000, 16'hFFFF, 0, 0, 1};
        vecs[15] = '{4,  0, 16'h0004, 16'hFFF4, 1, 0, 0};
        vecs[16] = '{2,  0, 16'h0042, 16'hFF42, 2, 0, 0};
        vecs[17] = '{18, 0, 16'h0042, 16'hFF42, 2, 1, 0};
        vecs[18] = '{6,  0, 16'h0042, 16'hFF42, 2, 0, 1};
        vecs[19] = '{17, 0, 16'h0042, 16'hFF42, 2, 0, 1};
        vecs[20] = '{16, 0, 16'h0000, 16'hFFFF, 0, 0, 0};

        do_reset();
        check("reset_seg", seg_data, 16'hFFFF);
        check("reset_entry", entry_value, 16'h0000);
        check("reset_count", digit_count, 0);
        check("reset_full", full, 0);
        check("reset_done", entry_done, 0);
        check("reset_reject", key_reject, 0);

        for (int i = 0; i < 21; i++) begin
            press(vecs[i].code, vecs[i].md, d_s, r_s);
            check($sformatf("vec%0d_entry", i), entry_value, vecs[i].ev);
            check($sformatf("vec%0d_seg", i), seg_data, vecs[i].seg);
            check($sformatf("vec%0d_count", i), digit_count, vecs[i].cnt);
            check($sformatf("vec%0d_full", i), full, (vecs[i].cnt == N) ? 1 : 0);
            check($sformatf("vec%0d_done", i), d_s, vecs[i].done);
            check($sformatf("vec%0d_reject", i), r_s, vecs[i].rej);
            check($sformatf("vec%0d_pulse_len", i), {entry_done, key_reject}, 0);
        end

        // Key held low for 50 cycles gives a single event.
        keycode = KW'(7);
        mode = 2'b00;
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        repeat (50) tick();
        check("held_count", digit_count, 1);
        check("held_entry", entry_value, 16'h0007);

        // Strobe falls while reset is asserted: no event after release.
        do_reset();
        keycode = KW'(3);
        key_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        key_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rstrel_count", digit_count, 0);
        check("rstrel_entry", entry_value, 16'h0000);
        check("rstrel_reject", key_reject, 0);

        // Asynchronous reset while FULL, then a fresh first digit.
        do_reset();
        for (int k = 1; k <= 4; k++) press(k + 4, 0, d_s, r_s);
        check("full_before_rst", full, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_seg", seg_data, 16'hFFFF);
        check("async_rst_entry", entry_value, 16'h0000);
        check("async_rst_count", digit_count, 0);
        check("async_rst_full", full, 0);
        tick();
        rst = 1'b0;
        tick();
        press(1, 0, d_s, r_s);
        check("post_rst_entry", entry_value, 16'h0001);
        check("post_rst_count", digit_count, 1);
        check("post_rst_seg", seg_data, 16'hFFF1);

        // Randomized key stream against the reference model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int r, code, md;
            r = int'($urandom_range(0, 99));
            if (r < 58) code = int'($urandom_range(0, 9));
            else if (r < 64) code = 16;
            else if (r < 78) code = 17;
            else if (r < 88) code = 18;
            else begin
                code = int'($urandom_range(10, 25));
                if (code > 15) code = code + 3;
            end
            md = int'($urandom_range(0, 3));
            press(code, md, d_s, r_s);
            model_apply(code, md, md_done, md_rej);
            check($sformatf("rnd%0d_entry", n), entry_value, model_entry());
            check($sformatf("rnd%0d_seg", n), seg_data, model_seg());
            check($sformatf("rnd%0d_count", n), digit_count, m_q.size());
            check($sformatf("rnd%0d_full", n), full, (m_q.size() == N) ? 1 : 0);
            check($sformatf("rnd%0d_done", n), d_s, md_done);
            check($sformatf("rnd%0d_reject", n), r_s, md_rej);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
